wave_meas_seq: RTL

WAVE_MEAS_SEQ -- requirements
Module: wave_meas_seq

---
 rtl/wave_pkg.sv | 21 ++
 rtl/wave_serial_div.sv | 53 +++++
 rtl/wave_meas_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared state encoding, datapath widths and helpers for the waveform meter
package wave_pkg;

    localparam int ACC_W = 32;
    localparam int DIV_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQ,
        S_DCCAL,
        S_SQACC,
        S_DIV,
        S_JUDGE,
        S_OUT
    } wave_state_t;

    function automatic logic [7:0] sat_u8(input logic [DIV_W-1:0] q);
        return (|q[DIV_W-1:8]) ? 8'hFF : q[7:0];
    endfunction

endpackage

// File: rtl/wave_serial_div.sv
// rtl/wave_serial_div.sv - restoring divider, one quotient bit per clock
module wave_serial_div
    import wave_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [ACC_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int CW = $clog2(DIV_W);

    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] rem;
    logic [ACC_W-1:0] src_rem;
    logic [ACC_W-1:0] nxt_rem;
    logic [DIV_W-1:0] dvd;
    logic [DIV_W-1:0] src_dvd;
    logic [ACC_W:0]   trial;
    logic             ge;

    // The start cycle already performs the first iteration on the fresh operands,
    // so all DIV_W quotient bits are in place after exactly DIV_W clocks.
    always_comb begin
        src_rem = start ? '0 : rem;
        src_dvd = start ? dividend : dvd;
        trial   = {src_rem, src_dvd[DIV_W-1]};
        ge      = trial >= {1'b0, divisor};
        nxt_rem = ge ? (trial[ACC_W-1:0] - divisor) : trial[ACC_W-1:0];
    end

    assign done     = busy && (cnt == CW'(DIV_W - 1));
    assign quotient = dvd;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            dvd  <= '0;
        end else if (start || busy) begin
            rem  <= nxt_rem;
            dvd  <= {src_dvd[DIV_W-2:0], ge};
            cnt  <= start ? CW'(1) : cnt + 1'b1;
            busy <= start ? 1'b1 : !done;
        end
    end

endmodule

// File: rtl/wave_meas_seq.sv
// rtl/wave_meas_seq.sv - windowed waveform measurement: vpp, dc offset, papr and sine decision
module wave_meas_seq
    import wave_pkg::*;
#(
    parameter int N                   = 8,
    parameter int SAMPLE_POINTS       = 64,
    parameter int LOG_2_SAMPLE_POINTS = 6,
    parameter int FRE_DIV             = 1249,
    parameter int JUDGE_THRESHOLD     = 700
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cont,
    input  logic [N-1:0] data_in_unsigned,
    output logic         sample_en,
    output logic         busy,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [N-1:0] vpp,
    output logic [N-1:0] dc_offset,
    output logic [7:0]   papr,
    output logic         is_sine_wave
);

    localparam int DCW = (FRE_DIV > 0) ? $clog2(FRE_DIV + 1) : 1;
    localparam int IW  = LOG_2_SAMPLE_POINTS;

    wave_state_t state, state_nxt;

    logic [DCW-1:0]    div_cnt;
    logic [IW-1:0]     idx;
    logic [N-1:0]      sbuf [SAMPLE_POINTS];
    logic [N-1:0]      max_r, min_r;
    logic [N-1:0]      vpp_r, dc_r;
    logic [DIV_W-1:0]  vpp_sq;
    logic [ACC_W-1:0]  acc;

    logic [N:0]            range_dif, range_sum;
    logic signed [N:0]     mul_a;
    logic signed [2*N+1:0] mul_p;
    logic [ACC_W-1:0]      vrms2, sq_ref, abs_err;
    logic signed [ACC_W-1:0] err;
    logic                  last_idx;
    logic                  div_start, div_busy, div_done;
    logic [DIV_W-1:0]      quot;

    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_OUT);
    assign sample_en    = (state == S_ACQ) && (div_cnt == DCW'(FRE_DIV));
    assign last_idx     = (idx == IW'(SAMPLE_POINTS - 1));

    assign range_dif = {1'b0, max_r} - {1'b0, min_r};
    assign range_sum = {1'b0, max_r} + {1'b0, min_r};

    // Single squarer: vpp in DCCAL, (x - dc) for each buffered sample in SQACC.
    always_comb begin
        if (state == S_SQACC) begin
            mul_a = $signed({1'b0, sbuf[idx]}) - $signed({1'b0, dc_r});
        end else begin
            mul_a = $signed(range_dif);
        end
    end
    assign mul_p = mul_a * mul_a;

    assign vrms2   = acc >> LOG_2_SAMPLE_POINTS;
    assign sq_ref  = ACC_W'(vpp_sq >> 3);
    assign err     = $signed(vrms2) - $signed(sq_ref);
    assign abs_err = err[ACC_W-1] ? ACC_W'(-err) : ACC_W'(err);

    wave_serial_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (vpp_sq),
        .divisor  (vrms2),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quot)
    );

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        unique case (state)
            S_IDLE:  if (start || cont) state_nxt = S_ACQ;
            S_ACQ:   if (sample_en && last_idx) state_nxt = S_DCCAL;
            S_DCCAL: state_nxt = S_SQACC;
            S_SQACC: if (last_idx) state_nxt = S_DIV;
            S_DIV: begin
                div_start = !div_busy;
                if (div_done) state_nxt = S_JUDGE;
            end
            S_JUDGE: state_nxt = S_OUT;
            S_OUT:   if (result_ready) state_nxt = cont ? S_ACQ : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sample_en) sbuf[idx] <= data_in_unsigned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            idx          <= '0;
            max_r        <= '0;
            min_r        <= '1;
            vpp_r        <= '0;
            dc_r         <= '0;
            vpp_sq       <= '0;
            acc          <= '0;
            vpp          <= '0;
            dc_offset    <= '0;
            papr         <= '0;
            is_sine_wave <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                // Both states that can lead into ACQ prepare a clean window.
                S_IDLE, S_OUT: begin
                    div_cnt <= '0;
                    idx     <= '0;
                    max_r   <= '0;
                    min_r   <= '1;
                end
                S_ACQ: begin
                    if (sample_en) begin
                        div_cnt <= '0;
                        idx     <= idx + 1'b1;
                        if (data_in_unsigned > max_r) max_r <= data_in_unsigned;
                        if (data_in_unsigned < min_r) min_r <= data_in_unsigned;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_DCCAL: begin
                    vpp_r  <= range_dif[N-1:0];
                    dc_r   <= N'(range_sum >> 1);
                    vpp_sq <= DIV_W'(mul_p);
                    acc    <= '0;
                    idx    <= '0;
                end
                S_SQACC: begin
                    acc <= acc + ACC_W'(mul_p);
                    idx <= idx + 1'b1;
                end
                S_JUDGE: begin
                    vpp          <= vpp_r;
                    dc_offset    <= dc_r;
                    papr         <= (vrms2 == '0) ? 8'd0 : sat_u8(quot);
                    is_sine_wave <= (abs_err < ACC_W'(JUDGE_THRESHOLD));
                end
                default: ;
            endcase
        end
    end

endmodule
